seq_alu: RTL

Multi-cycle ALU that sits directly upstream of the status register: it computes a result from two latched operands and produces the Zero, Negative and Overflow flags. Add, subtract, AND and OR complete in one cycle; signed multiply runs as an iterative shift-add over WIDTH cycles. A one-cycle done pulse doubles as the status register's update enable, so the flags are captured exactly once per completed operation.

---
 rtl/seq_alu_pkg.sv | 15 +
 rtl/seq_alu_mul.sv | 46 ++++
 rtl/seq_alu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes and FSM states shared by seq_alu and its multiplier core
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - iterative unsigned shift-add multiplier core, one partial product per step
module seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   ma,
  input  logic [WIDTH-1:0]   mb,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // Accumulator value after the current step; the top captures it on the last step.
  assign prod_next = acc + (mplier[0] ? mcand : '0);
  assign last      = (cnt == CW'(WIDTH - 1));

  // Load magnitudes, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, ma};
      mplier <= mb;
      cnt    <= '0;
    end else if (step) begin
      acc    <= prod_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with Z/N/V flags and done pulse; SEQ_ALU_MUL_EN builds signed MUL
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             pend;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_v;

`ifdef SEQ_ALU_MUL_EN
  state_e             state;
  logic               busy_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] mag_p;
  logic [2*WIDTH-1:0] sgn_p;
  logic               mul_last;
  logic               mul_load;
  logic               mul_step;
  logic               mul_fin;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_v;

  assign busy     = busy_q;
  assign accept   = start && !busy_q;
  assign mag_a    = a[WIDTH-1] ? -a : a;
  assign mag_b    = b[WIDTH-1] ? -b : b;
  assign mul_load = accept && (op == OP_MUL);
  assign mul_step = (state == ST_MUL);
  assign mul_fin  = mul_step && mul_last;
  assign sgn_p    = neg_q ? -mag_p : mag_p;
  assign mul_res  = sgn_p[WIDTH-1:0];
  // Representable only if the top WIDTH+1 product bits are a pure sign extension.
  assign mul_v    = !((&sgn_p[2*WIDTH-1:WIDTH-1]) || !(|sgn_p[2*WIDTH-1:WIDTH-1]));

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .ma        (mag_a),
    .mb        (mag_b),
    .prod_next (mag_p),
    .last      (mul_last)
  );
`else
  assign busy   = 1'b0;
  assign accept = start;
`endif

  // Single-cycle operations on the latched operands; anything unrecognised is illegal.
  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    alu_res = '0;
    alu_v   = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: begin
        alu_res = a_q & b_q;
        alu_v   = 1'b0;
      end
      OP_OR: begin
        alu_res = a_q | b_q;
        alu_v   = 1'b0;
      end
      default: begin
        alu_res = '0;
        alu_v   = 1'b1;
      end
    endcase
  end

  // Pick which completing operation updates result/flags this edge.
  always_comb begin
    wr_en  = pend;
    wr_res = alu_res;
    wr_v   = alu_v;
`ifdef SEQ_ALU_MUL_EN
    if (mul_fin) begin
      wr_en  = 1'b1;
      wr_res = mul_res;
      wr_v   = mul_v;
    end
`endif
  end

  // Control FSM: latch operands on accept, write result/flags and pulse done on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      pend   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      v      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
`endif
    end else begin
      done <= wr_en;
      pend <= 1'b0;
      if (wr_en) begin
        result <= wr_res;
        z      <= (wr_res == '0);
        n      <= wr_res[WIDTH-1];
        v      <= wr_v;
      end
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
`ifdef SEQ_ALU_MUL_EN
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state  <= ST_MUL;
              busy_q <= 1'b1;
              neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
              pend <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
`else
      if (accept) pend <= 1'b1;
`endif
    end
  end

endmodule
